tdm_demux2: RTL and testbench
=============================

TDM_DEMUX2 -- requirements
Module: tdm_demux2

Interface
REQ-001 Parameter: W, 8, word width per channel (legal range 2..16).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: din  input  1  interleaved serial data; slot A bit, then slot B bit, alternating.
REQ-005 Port: din_valid  input  1  din is sampled only on cycles where this is 1.
REQ-006 Port: sof  input  1  start-of-frame; qualified by din_valid; marks slot A bit 0.
REQ-007 Port: sel  output  1  slot of the next expected bit (0 = A, 1 = B); mirrors the transmit-side mux select.
REQ-008 Port: a_data  output  W  last completed channel A word.
REQ-009 Port: b_data  output  W  last completed channel B word.
REQ-010 Port: word_valid  output  1  one-cycle pulse: a_data/b_data updated.
REQ-011 Port: frame_err  output  1  one-cycle pulse: frame aborted by early sof.

Function
REQ-012 Frame: exactly 2*W valid bits; order A0,B0,A1,B1,...,A(W-1),B(W-1); LSB first.
REQ-013 States: IDLE (awaiting sof), RUN (collecting frame).
REQ-014 IDLE: valid bits without sof ignored; sel held 0; no output change.
REQ-015 IDLE -> RUN: din_valid=1 and sof=1; that bit captured as A0; sel becomes 1.
REQ-016 RUN: each valid bit goes to the lane selected by sel; sel toggles; bit index increments after each B bit.
REQ-017 Cycles with din_valid=0 hold all state; gaps of any length allowed mid-frame.
REQ-018 Capture of B(W-1): a_data and b_data loaded together from lane shift registers; word_valid=1 on the following cycle only; state returns to IDLE; sel=0.
REQ-019 Latency: word_valid asserts exactly 1 clock after the edge that samples B(W-1).
REQ-020 Back-to-back: sof on the cycle immediately after B(W-1) starts a new frame with no error and no lost bit.
REQ-021 sof with din_valid=1 while in RUN (mid-frame): partial frame discarded; frame_err pulses next cycle; that bit captured as A0 of a new frame; a_data/b_data unchanged.
REQ-022 sof with din_valid=0: ignored in all states.
REQ-023 a_data/b_data hold their value between frames; never show partial words.
REQ-024 word_valid and frame_err never assert in the same cycle.

Reset
REQ-025 rst=1 forces immediately, independent of clk: state IDLE, sel=0, a_data=0, b_data=0, word_valid=0, frame_err=0, lane registers=0, bit index=0.
REQ-026 rst mid-frame discards the partial frame without a frame_err pulse.
REQ-027 First frame after rst release requires sof.

Structure
REQ-028 Shared package holds: default W, state encoding (IDLE, RUN), bit-index width constant ($clog2(W)).
REQ-029 One sub-module tdm_lane: W-bit LSB-first shift register with shift-enable and clear; instantiated twice (A, B).
REQ-030 Top holds the FSM, sel toggle, bit index, output registers and pulse generation.

Verification
REQ-031 W=8, sof + 16 contiguous bits encoding A=0xA5, B=0x3C -> word_valid one cycle after last bit; a_data=0xA5, b_data=0x3C.
REQ-032 Same frame with din_valid=0 for 3 cycles after every 2nd bit -> identical outputs; word_valid once.
REQ-033 Frame A=0x01,B=0x80 then sof on the very next cycle for A=0xFF,B=0x00 -> two word_valid pulses, no frame_err, outputs 0x01/0x80 then 0xFF/0x00.
REQ-034 sof after 7 bits of a frame, then complete frame A=0x55,B=0xAA -> frame_err one pulse; outputs keep prior value until word_valid; then 0x55/0xAA.
REQ-035 rst asserted after 9 bits -> all outputs 0 asynchronously; 16 bits without sof -> no word_valid; then valid frame decodes correctly.
REQ-036 sel checked every cycle against bit-slot model; 20 valid bits without sof in IDLE -> sel stays 0, outputs unchanged.

Source files
------------

// File: rtl/tdm_demux2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux2_pkg
// Brief    : Shared constants, state encoding and helpers for tdm_demux2.
// Revision : 1.0 - initial release
// ============================================================================
package tdm_demux2_pkg;

    localparam int unsigned c_w_default     = 8;
    localparam int unsigned c_idx_w_default = $clog2(c_w_default);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Bit-index width for a given word width; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tdm_lane.sv
`default_nettype none
// ============================================================================
// Module   : tdm_lane
// Brief    : W-bit LSB-first shift register with shift-enable and clear.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_lane #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         shift_en,
    input  logic         bit_in,
    output logic [W-1:0] data
);

    logic [W-1:0] r_sr;

    // Clear together with shift loads the new bit as the first bit of a fresh word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr <= '0;
        end else if (clr && shift_en) begin
            r_sr <= {bit_in, {(W-1){1'b0}}};
        end else if (clr) begin
            r_sr <= '0;
        end else if (shift_en) begin
            r_sr <= {bit_in, r_sr[W-1:1]};
        end
    end

    assign data = r_sr;

endmodule
`default_nettype wire

// File: rtl/tdm_demux2.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux2
// Brief    : Two-slot TDM serial demultiplexer producing A/B parallel words.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_demux2
    import tdm_demux2_pkg::*;
#(
    parameter int W = c_w_default
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         din,
    input  logic         din_valid,
    input  logic         sof,
    output logic         sel,
    output logic [W-1:0] a_data,
    output logic [W-1:0] b_data,
    output logic         word_valid,
    output logic         frame_err
);

    localparam int unsigned          c_idx_w    = idx_width(W);
    localparam logic [c_idx_w-1:0]   c_last_idx = c_idx_w'(W - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_sel;
    logic                 w_sel_nxt;
    logic [c_idx_w-1:0]   r_idx;
    logic [c_idx_w-1:0]   w_idx_nxt;
    logic [W-1:0]         r_a_data;
    logic [W-1:0]         w_a_data_nxt;
    logic [W-1:0]         r_b_data;
    logic [W-1:0]         w_b_data_nxt;
    logic                 r_word_valid;
    logic                 w_word_valid_nxt;
    logic                 r_frame_err;
    logic                 w_frame_err_nxt;

    logic                 w_clr;
    logic                 w_shift_a;
    logic                 w_shift_b;
    logic [W-1:0]         w_lane_a;
    logic [W-1:0]         w_lane_b;

    tdm_lane #(.W(W)) u_lane_a (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_clr),
        .shift_en (w_shift_a),
        .bit_in   (din),
        .data     (w_lane_a)
    );

    tdm_lane #(.W(W)) u_lane_b (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_clr),
        .shift_en (w_shift_b),
        .bit_in   (din),
        .data     (w_lane_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_sel        <= 1'b0;
            r_idx        <= '0;
            r_a_data     <= '0;
            r_b_data     <= '0;
            r_word_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sel        <= w_sel_nxt;
            r_idx        <= w_idx_nxt;
            r_a_data     <= w_a_data_nxt;
            r_b_data     <= w_b_data_nxt;
            r_word_valid <= w_word_valid_nxt;
            r_frame_err  <= w_frame_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_sel_nxt        = r_sel;
        w_idx_nxt        = r_idx;
        w_a_data_nxt     = r_a_data;
        w_b_data_nxt     = r_b_data;
        w_word_valid_nxt = 1'b0;
        w_frame_err_nxt  = 1'b0;
        w_clr            = 1'b0;
        w_shift_a        = 1'b0;
        w_shift_b        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (din_valid && sof) begin
                    w_state_nxt = ST_RUN;
                    w_sel_nxt   = 1'b1;
                    w_idx_nxt   = '0;
                    w_clr       = 1'b1;
                    w_shift_a   = 1'b1;
                end
            end

            ST_RUN: begin
                if (din_valid) begin
                    if (sof) begin
                        // Early sof restarts the frame; the sof bit is the new A0.
                        w_frame_err_nxt = 1'b1;
                        w_sel_nxt       = 1'b1;
                        w_idx_nxt       = '0;
                        w_clr           = 1'b1;
                        w_shift_a       = 1'b1;
                    end else if (!r_sel) begin
                        w_shift_a = 1'b1;
                        w_sel_nxt = 1'b1;
                    end else begin
                        w_shift_b = 1'b1;
                        w_sel_nxt = 1'b0;
                        if (r_idx == c_last_idx) begin
                            // B(W-1) is still on din; merge it into the B word directly.
                            w_a_data_nxt     = w_lane_a;
                            w_b_data_nxt     = {din, w_lane_b[W-1:1]};
                            w_word_valid_nxt = 1'b1;
                            w_state_nxt      = ST_IDLE;
                            w_idx_nxt        = '0;
                        end else begin
                            w_idx_nxt = r_idx + c_idx_w'(1);
                        end
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_sel_nxt   = 1'b0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    assign sel        = r_sel;
    assign a_data     = r_a_data;
    assign b_data     = r_b_data;
    assign word_valid = r_word_valid;
    assign frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux2.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdm_demux2
// Brief    : Scoreboard bench for tdm_demux2 with a bit-slot reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_demux2;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         din;
    logic         din_valid;
    logic         sof;
    logic         sel;
    logic [W-1:0] a_data;
    logic [W-1:0] b_data;
    logic         word_valid;
    logic         frame_err;

    int n_chk  = 0;
    int n_pass = 0;

    logic [2*W-1:0] sb_q[$];

    logic         m_active;
    int           m_cnt;
    logic [W-1:0] m_acc_a;
    logic [W-1:0] m_acc_b;
    logic [W-1:0] m_a;
    logic [W-1:0] m_b;
    logic         m_sel;
    logic         m_wv;
    logic         m_fe;

    tdm_demux2 #(.W(W)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .sof        (sof),
        .sel        (sel),
        .a_data     (a_data),
        .b_data     (b_data),
        .word_valid (word_valid),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_cnt    = 0;
        m_acc_a  = '0;
        m_acc_b  = '0;
        m_a      = '0;
        m_b      = '0;
        m_sel    = 1'b0;
        m_wv     = 1'b0;
        m_fe     = 1'b0;
    endtask

    // Apply one cycle of input, advance the model at the edge, check at the next negedge.
    task automatic drive(input logic v, input logic s, input logic d);
        logic [2*W-1:0] exp_w;
        din_valid = v;
        sof       = s;
        din       = d;
        @(posedge clk);
        m_wv = 1'b0;
        m_fe = 1'b0;
        if (v) begin
            if (s) begin
                if (m_active) m_fe = 1'b1;
                m_active = 1'b1;
                m_cnt    = 0;
                m_acc_a  = '0;
                m_acc_b  = '0;
            end
            if (m_active) begin
                if (m_cnt % 2 == 0) m_acc_a[m_cnt/2] = d;
                else                m_acc_b[m_cnt/2] = d;
                m_cnt++;
                if (m_cnt == 2*W) begin
                    m_active = 1'b0;
                    m_wv     = 1'b1;
                    m_a      = m_acc_a;
                    m_b      = m_acc_b;
                    sb_q.push_back({m_acc_a, m_acc_b});
                end
            end
        end
        m_sel = m_active ? m_cnt[0] : 1'b0;
        @(negedge clk);
        chk("sel", 32'(sel), 32'(m_sel));
        chk("word_valid", 32'(word_valid), 32'(m_wv));
        chk("frame_err", 32'(frame_err), 32'(m_fe));
        chk("a_data_hold", 32'(a_data), 32'(m_a));
        chk("b_data_hold", 32'(b_data), 32'(m_b));
        if (word_valid) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_word", 32'(1), 32'(0));
            end else begin
                exp_w = sb_q.pop_front();
                chk("sb_a_data", 32'(a_data), 32'(exp_w[2*W-1:W]));
                chk("sb_b_data", 32'(b_data), 32'(exp_w[W-1:0]));
            end
        end
    endtask

    task automatic send_bits(input logic [W-1:0] a, input logic [W-1:0] b,
                             input int nbits, input bit gaps);
        logic bitv;
        for (int i = 0; i < nbits; i++) begin
            bitv = (i % 2 == 0) ? a[i/2] : b[i/2];
            drive(1'b1, (i == 0), bitv);
            // Gap cycles carry a random sof that must be ignored.
            if (gaps && (i % 2 == 1)) begin
                for (int g = 0; g < 3; g++) drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic async_reset_check();
        #2 rst = 1'b1;
        #1;
        chk("rst_a_data", 32'(a_data), 32'(0));
        chk("rst_b_data", 32'(b_data), 32'(0));
        chk("rst_sel", 32'(sel), 32'(0));
        chk("rst_word_valid", 32'(word_valid), 32'(0));
        chk("rst_frame_err", 32'(frame_err), 32'(0));
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        din       = 1'b0;
        din_valid = 1'b0;
        sof       = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("init_a_data", 32'(a_data), 32'(0));
        chk("init_b_data", 32'(b_data), 32'(0));
        chk("init_sel", 32'(sel), 32'(0));
        chk("init_word_valid", 32'(word_valid), 32'(0));
        rst = 1'b0;
        idle(2);

        // Contiguous frame.
        send_bits(8'hA5, 8'h3C, 2*W, 1'b0);
        idle(3);

        // Same frame with gaps after every second bit.
        send_bits(8'hA5, 8'h3C, 2*W, 1'b1);
        idle(3);

        // Back-to-back frames.
        send_bits(8'h01, 8'h80, 2*W, 1'b0);
        send_bits(8'hFF, 8'h00, 2*W, 1'b0);
        idle(3);

        // Aborted frame followed by a full frame.
        send_bits(8'hC3, 8'h96, 7, 1'b0);
        send_bits(8'h55, 8'hAA, 2*W, 1'b0);
        idle(3);

        // Asynchronous reset mid-frame, then bits without sof, then a valid frame.
        send_bits(8'h5A, 8'hE7, 9, 1'b0);
        async_reset_check();
        for (int i = 0; i < 2*W; i++) drive(1'b1, 1'b0, 1'($urandom_range(0, 1)));
        send_bits(8'h69, 8'h0F, 2*W, 1'b0);
        idle(2);

        // Idle valid bits without sof must leave everything untouched.
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 1'($urandom_range(0, 1)));
        idle(2);

        chk("sb_drained", 32'(sb_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
